am_bip_sequencer: RTL

- Per-lane TX controller that sequences the BIP calculator and inserts 100GBASE-R alignment markers (AMs) into the 66-bit block stream.
- Counts data blocks between markers, back-pressures upstream during the AM slot, and builds the AM word with the lane's M0..M6 and the calculator's current BIP3/BIP7.
- Drives the calculator's enable, valid, start-of-lane and AM-insert controls.
- Sits between the lane distributor and the per-lane BIP calculator/serializer.

---
 rtl/pcs_am_pkg.sv | 24 ++
 rtl/am_lane_rom.sv | 33 +++
 rtl/am_bip_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pcs_am_pkg.sv
// Shared constants for 100GBASE-R alignment marker insertion: the per-lane
// marker table, the AM sync header and the sequencer state encoding.
package pcs_am_pkg;

    localparam int NB_LANES  = 20;
    localparam int NB_MARKER = 24;

    localparam logic [1:0] AM_SYNC_HDR = 2'b10;

    // {M0, M1, M2} for PCS lanes 0..19
    localparam logic [NB_MARKER-1:0] AM_MARKERS [NB_LANES] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    typedef enum logic [1:0] {
        ST_SOL_AM = 2'd0,
        ST_DATA   = 2'd1,
        ST_AM     = 2'd2
    } am_state_t;

endpackage

// File: rtl/am_lane_rom.sv
// Lane-number to alignment-marker lookup. Unknown lanes return zero markers
// and raise o_err so the caller can flag a misconfigured lane.
module am_lane_rom
    import pcs_am_pkg::*;
#(
    parameter int NB_LANE_ID = 5
) (
    input  logic [NB_LANE_ID-1:0] i_lane_id,
    output logic [7:0]            o_m0,
    output logic [7:0]            o_m1,
    output logic [7:0]            o_m2,
    output logic                  o_err
);

    logic [NB_MARKER-1:0] marker;

    // Scan the table so out-of-range ids fall through to zero markers
    always_comb begin
        marker = '0;
        o_err  = 1'b1;
        for (int i = 0; i < NB_LANES; i++) begin
            if (int'(i_lane_id) == i) begin
                marker = AM_MARKERS[i];
                o_err  = 1'b0;
            end
        end
    end

    assign o_m0 = marker[23:16];
    assign o_m1 = marker[15:8];
    assign o_m2 = marker[7:0];

endmodule

// File: rtl/am_bip_sequencer.sv
// Per-lane TX alignment-marker sequencer. Counts data blocks between AMs,
// stalls upstream during the AM slot and builds the AM word from the lane
// markers and the BIP calculator's current BIP3/BIP7. Data path is
// combinational from registered state, so blocks pass with zero latency.
module am_bip_sequencer
    import pcs_am_pkg::*;
#(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int NB_BIP          = 8,
    parameter int AM_PERIOD       = 16384,
    parameter int NB_LANE_ID      = 5,
    parameter int NB_COUNT        = 14
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_restart,
    input  logic [NB_LANE_ID-1:0]      i_lane_id,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [NB_BIP-1:0]          i_bip3,
    input  logic [NB_BIP-1:0]          i_bip7,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_bip_enable,
    output logic                       o_am_insert,
    output logic                       o_start_of_lane,
    output logic                       o_lane_err
);

    // Last data block of a period is the one transferred at this count
    localparam logic [NB_COUNT-1:0] TERM_COUNT = NB_COUNT'(AM_PERIOD - 2);

    am_state_t                  state_q;
    am_state_t                  state_d;
    logic [NB_COUNT-1:0]        count_q;
    logic [NB_COUNT-1:0]        count_d;
    logic                       lane_err_q;
    logic [7:0]                 m0;
    logic [7:0]                 m1;
    logic [7:0]                 m2;
    logic                       rom_err;
    logic [LEN_CODED_BLOCK-1:0] am_word;

    am_lane_rom #(
        .NB_LANE_ID (NB_LANE_ID)
    ) u_lane_rom (
        .i_lane_id (i_lane_id),
        .o_m0      (m0),
        .o_m1      (m1),
        .o_m2      (m2),
        .o_err     (rom_err)
    );

    // BIP fields come straight from the calculator: parity up to, not
    // including, this AM
    assign am_word = {AM_SYNC_HDR, m0, m1, m2, i_bip3, ~m0, ~m1, ~m2, i_bip7};

    assign o_bip_enable = i_enable;
    assign o_lane_err   = lane_err_q & ~i_reset;

    // State, period counter and lane-error flag; everything freezes when disabled
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_SOL_AM;
            count_q    <= '0;
            lane_err_q <= 1'b0;
        end else if (i_enable) begin
            state_q    <= state_d;
            count_q    <= count_d;
            lane_err_q <= rom_err;
        end
    end

    // Next-state and output decode; restart overrides the terminal-count jump
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        o_data          = '0;
        o_valid         = 1'b0;
        o_ready         = 1'b0;
        o_am_insert     = 1'b0;
        o_start_of_lane = 1'b0;
        if (!i_reset && i_enable) begin
            case (state_q)
                ST_SOL_AM: begin
                    o_data          = am_word;
                    o_valid         = 1'b1;
                    o_am_insert     = 1'b1;
                    o_start_of_lane = 1'b1;
                    state_d         = ST_DATA;
                    count_d         = '0;
                end
                ST_DATA: begin
                    o_data  = i_data;
                    o_valid = i_valid;
                    o_ready = 1'b1;
                    if (i_valid) begin
                        if (count_q == TERM_COUNT) begin
                            state_d = ST_AM;
                            count_d = '0;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_AM: begin
                    o_data      = am_word;
                    o_valid     = 1'b1;
                    o_am_insert = 1'b1;
                    state_d     = ST_DATA;
                end
                default: begin
                    state_d = ST_SOL_AM;
                    count_d = '0;
                end
            endcase
            if (i_restart) begin
                state_d = ST_SOL_AM;
                count_d = '0;
            end
        end
    end

endmodule
